// File: rtl/mem_latency_model.sv
// Fixed-latency memory front end: captures one request, waits READ/WRITE_LATENCY, strobes the array, then pulses completion.
// Completion arrives LATENCY+2 cycles after capture; requests are level-held, and a new one is taken only after both drop.
module mem_latency_model #(
   parameter int ADDR_WIDTH    = 64,
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_BYTES     = 4096,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 2
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic                  write_en_i,
   input  logic                  read_request_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] read_data_o,
   output logic                  successful_access_o,
   output logic                  successful_read_o,
   output logic                  successful_write_o,
   output logic                  mem_we_o,
   output logic                  mem_re_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i
);

   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0]         RD_LOAD   = CW'(READ_LATENCY - 1);
   localparam logic [CW-1:0]         WR_LOAD   = CW'(WRITE_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_BYTES - 4);

   typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RESP, HOLD} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  is_wr_q, is_wr_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  ok_q, ok_d;
   logic                  rd_pulse_q, rd_pulse_d;
   logic                  wr_pulse_q, wr_pulse_d;
   logic                  fault;

   assign fault = (addr_q[1:0] != 2'b00) || (addr_q > LAST_ADDR);

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         is_wr_q    <= 1'b0;
         rd_data_q  <= '0;
         ok_q       <= 1'b0;
         rd_pulse_q <= 1'b0;
         wr_pulse_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         is_wr_q    <= is_wr_d;
         rd_data_q  <= rd_data_d;
         ok_q       <= ok_d;
         rd_pulse_q <= rd_pulse_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      is_wr_d    = is_wr_q;
      rd_data_d  = rd_data_q;
      ok_d       = ok_q;
      rd_pulse_d = 1'b0;
      wr_pulse_d = 1'b0;
      mem_we_o   = 1'b0;
      mem_re_o   = 1'b0;
      mem_addr_o = '0;
      mem_data_o = '0;
      case (state_q)
         IDLE: begin
            // A write wins over a simultaneous read.
            if (write_en_i || read_request_i) begin
               addr_d  = addr_i;
               data_d  = data_i;
               is_wr_d = write_en_i;
               cnt_d   = write_en_i ? WR_LOAD : RD_LOAD;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = ACCESS;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ACCESS: begin
            if (!fault) begin
               mem_we_o   = is_wr_q;
               mem_re_o   = !is_wr_q;
               mem_addr_o = addr_q >> 2;
               mem_data_o = data_q;
            end
            state_d = RESP;
         end
         RESP: begin
            // Array read data is valid here, one cycle after the read strobe.
            wr_pulse_d = is_wr_q;
            rd_pulse_d = !is_wr_q;
            ok_d       = !fault;
            rd_data_d  = (!is_wr_q && !fault) ? mem_data_i : '0;
            state_d    = HOLD;
         end
         HOLD: begin
            if (!write_en_i && !read_request_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign read_data_o         = rd_data_q;
   assign successful_access_o = ok_q;
   assign successful_read_o   = rd_pulse_q;
   assign successful_write_o  = wr_pulse_q;

endmodule

// File: tb/tb_mem_latency_model.sv
// Bench for mem_latency_model: directed scenarios plus random traffic against a word-array reference.
module tb_mem_latency_model;
   localparam int AW = 64;
   localparam int DW = 32;
   localparam int MB = 4096;
   localparam int RL = 4;
   localparam int WL = 2;

   logic          clk_i = 1'b0;
   logic          arst_i = 1'b0;
   logic          write_en_i = 1'b0;
   logic          read_request_i = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic [DW-1:0] data_i = '0;
   logic [DW-1:0] mem_data_i = '0;
   logic [DW-1:0] read_data_o;
   logic          successful_access_o, successful_read_o, successful_write_o;
   logic          mem_we_o, mem_re_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_data_o;

   int checks = 0;
   int errors = 0;

   // Backing array seen by the DUT, and the bench's independent reference copy.
   logic [DW-1:0] tb_arr  [0:MB/4-1] = '{default: '0};
   logic [DW-1:0] ref_mem [0:MB/4-1] = '{default: '0};

   // Observations of the most recent transaction window.
   int            o_we_n, o_re_n, o_strb_cyc, o_pulse_n, o_pulse_cyc;
   logic [AW-1:0] o_maddr;
   logic [DW-1:0] o_mdata, o_rdata;
   logic          o_swr, o_srd, o_sacc;

   mem_latency_model #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MB),
      .READ_LATENCY(RL), .WRITE_LATENCY(WL)
   ) dut (
      .clk_i(clk_i), .arst_i(arst_i),
      .write_en_i(write_en_i), .read_request_i(read_request_i),
      .addr_i(addr_i), .data_i(data_i),
      .read_data_o(read_data_o),
      .successful_access_o(successful_access_o),
      .successful_read_o(successful_read_o),
      .successful_write_o(successful_write_o),
      .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i)
   );

   always #5 clk_i = ~clk_i;

   // Array model: read data valid one cycle after the strobe, garbage otherwise.
   always @(posedge clk_i) begin
      if (mem_we_o) tb_arr[mem_addr_o[9:0]] <= mem_data_o;
      if (mem_re_o) mem_data_i <= tb_arr[mem_addr_o[9:0]];
      else          mem_data_i <= $urandom;
   end

   function automatic bit ref_fault(input logic [AW-1:0] a);
      return (a[1:0] != 2'b00) || (a > AW'(MB - 4));
   endfunction

   function automatic logic [DW-1:0] ref_read(input bit wr, input logic [AW-1:0] a);
      if (wr || ref_fault(a)) return '0;
      return ref_mem[a[11:2]];
   endfunction

   task automatic ref_apply(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (wr && !ref_fault(a)) ref_mem[a[11:2]] = d;
   endtask

   // Samples ncyc posedges; cycle 0 is the capture edge. Inputs are scrambled after capture.
   task automatic observe(input int ncyc);
      o_we_n = 0; o_re_n = 0; o_strb_cyc = -1; o_pulse_n = 0; o_pulse_cyc = -1;
      o_maddr = '0; o_mdata = '0; o_rdata = '0; o_swr = 0; o_srd = 0; o_sacc = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk_i); #1;
         if (mem_we_o) begin o_we_n++; o_strb_cyc = c; o_maddr = mem_addr_o; o_mdata = mem_data_o; end
         if (mem_re_o) begin o_re_n++; o_strb_cyc = c; o_maddr = mem_addr_o; end
         if (successful_read_o || successful_write_o) begin
            o_pulse_n++; o_pulse_cyc = c;
            o_swr = successful_write_o; o_srd = successful_read_o;
            o_sacc = successful_access_o; o_rdata = read_data_o;
         end
         if (c == 0) begin addr_i = {$urandom, $urandom}; data_i = $urandom; end
      end
   endtask

   task automatic run_txn(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk_i);
      write_en_i = wr; read_request_i = rd; addr_i = a; data_i = d;
      observe(20);
      @(negedge clk_i);
      write_en_i = 0; read_request_i = 0;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_reset;
      arst_i = 0; write_en_i = 1; read_request_i = 1; addr_i = 64'h10; data_i = 32'h1234_5678;
      repeat (3) @(posedge clk_i);
      #1;
      checks++; if ({mem_we_o, mem_re_o, successful_read_o, successful_write_o, successful_access_o} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000", {mem_we_o, mem_re_o, successful_read_o, successful_write_o, successful_access_o}); end
      checks++; if ({read_data_o, mem_data_o, mem_addr_o} !== '0) begin
         errors++; $display("FAIL reset_data got rd=%h md=%h ma=%h want 0", read_data_o, mem_data_o, mem_addr_o); end
      @(negedge clk_i);
      write_en_i = 0; read_request_i = 0; arst_i = 1;
      @(negedge clk_i);
   endtask

   task automatic test_write_legal;
      run_txn(1, 0, 64'h10, 32'hDEADBEEF);
      checks++; if (o_we_n !== 1 || o_re_n !== 0) begin errors++; $display("FAIL wr_strobes got we=%0d re=%0d want we=1 re=0", o_we_n, o_re_n); end
      checks++; if (o_strb_cyc !== WL) begin errors++; $display("FAIL wr_strobe_cycle got %0d want %0d", o_strb_cyc, WL); end
      checks++; if (o_maddr !== 64'h4 || o_mdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem_bus got a=%h d=%h want a=4 d=deadbeef", o_maddr, o_mdata); end
      checks++; if (o_pulse_n !== 1 || o_pulse_cyc !== WL + 2) begin errors++; $display("FAIL wr_pulse got n=%0d cyc=%0d want n=1 cyc=%0d", o_pulse_n, o_pulse_cyc, WL + 2); end
      checks++; if ({o_swr, o_srd, o_sacc} !== 3'b101) begin errors++; $display("FAIL wr_flags got %b want 101", {o_swr, o_srd, o_sacc}); end
      ref_apply(1, 64'h10, 32'hDEADBEEF);
   endtask

   task automatic test_read_legal;
      logic [DW-1:0] exp;
      exp = ref_read(0, 64'h10);
      run_txn(0, 1, 64'h10, 32'h0);
      checks++; if (o_re_n !== 1 || o_we_n !== 0) begin errors++; $display("FAIL rd_strobes got re=%0d we=%0d want re=1 we=0", o_re_n, o_we_n); end
      checks++; if (o_strb_cyc !== RL || o_maddr !== 64'h4) begin errors++; $display("FAIL rd_strobe got cyc=%0d a=%h want cyc=%0d a=4", o_strb_cyc, o_maddr, RL); end
      checks++; if (o_pulse_n !== 1 || o_pulse_cyc !== RL + 2) begin errors++; $display("FAIL rd_pulse got n=%0d cyc=%0d want n=1 cyc=%0d", o_pulse_n, o_pulse_cyc, RL + 2); end
      checks++; if ({o_swr, o_srd, o_sacc} !== 3'b011) begin errors++; $display("FAIL rd_flags got %b want 011", {o_swr, o_srd, o_sacc}); end
      checks++; if (o_rdata !== exp) begin errors++; $display("FAIL rd_data got %h want %h", o_rdata, exp); end
      checks++; if (read_data_o !== exp) begin errors++; $display("FAIL rd_data_hold got %h want %h", read_data_o, exp); end
   endtask

   task automatic test_faults;
      run_txn(0, 1, 64'h12, 32'h0);
      checks++; if (o_we_n + o_re_n !== 0) begin errors++; $display("FAIL misaligned_strobe got %0d want 0", o_we_n + o_re_n); end
      checks++; if (o_pulse_n !== 1 || {o_srd, o_sacc} !== 2'b10 || o_rdata !== '0) begin
         errors++; $display("FAIL misaligned_resp got n=%0d rd=%b acc=%b data=%h want n=1 rd=1 acc=0 data=0", o_pulse_n, o_srd, o_sacc, o_rdata); end
      run_txn(1, 0, 64'h1000, 32'hCAFEF00D);
      checks++; if (o_we_n + o_re_n !== 0) begin errors++; $display("FAIL range_strobe got %0d want 0", o_we_n + o_re_n); end
      checks++; if (o_pulse_n !== 1 || {o_swr, o_sacc} !== 2'b10 || read_data_o !== '0) begin
         errors++; $display("FAIL range_resp got n=%0d wr=%b acc=%b data=%h want n=1 wr=1 acc=0 data=0", o_pulse_n, o_swr, o_sacc, read_data_o); end
      run_txn(1, 0, 64'hFFC, 32'h0BAD_CAFE);
      checks++; if (o_we_n !== 1 || o_maddr !== 64'h3FF || o_sacc !== 1'b1) begin
         errors++; $display("FAIL top_word got we=%0d a=%h acc=%b want we=1 a=3ff acc=1", o_we_n, o_maddr, o_sacc); end
      ref_apply(1, 64'hFFC, 32'h0BAD_CAFE);
   endtask

   task automatic test_simultaneous;
      run_txn(1, 1, 64'h20, 32'h5A5A_A5A5);
      checks++; if (o_we_n !== 1 || o_re_n !== 0 || o_mdata !== 32'h5A5A_A5A5) begin
         errors++; $display("FAIL both_kind got we=%0d re=%0d d=%h want we=1 re=0 d=5a5aa5a5", o_we_n, o_re_n, o_mdata); end
      checks++; if (o_pulse_n !== 1 || o_swr !== 1'b1) begin errors++; $display("FAIL both_single got n=%0d wr=%b want n=1 wr=1", o_pulse_n, o_swr); end
      ref_apply(1, 64'h20, 32'h5A5A_A5A5);
   endtask

   task automatic test_reset_mid;
      logic [DW-1:0] exp;
      int            we_seen;
      exp = ref_read(0, 64'h20);
      we_seen = 0;
      @(negedge clk_i);
      write_en_i = 1; addr_i = 64'h30; data_i = 32'h1111_2222;
      @(posedge clk_i);
      @(negedge clk_i);
      arst_i = 0; write_en_i = 0; read_request_i = 1; addr_i = 64'h20;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk_i); #1;
         if (mem_we_o) we_seen++;
      end
      checks++; if ({read_data_o, mem_data_o, mem_addr_o, mem_we_o, mem_re_o, successful_read_o, successful_write_o, successful_access_o} !== '0) begin
         errors++; $display("FAIL midreset_outputs got nonzero rd=%h ma=%h want all 0", read_data_o, mem_addr_o); end
      @(negedge clk_i);
      arst_i = 1;
      observe(20);
      we_seen += o_we_n;
      checks++; if (we_seen !== 0) begin errors++; $display("FAIL midreset_we got %0d want 0", we_seen); end
      checks++; if (o_re_n !== 1 || o_strb_cyc !== RL || o_pulse_n !== 1 || o_pulse_cyc !== RL + 2) begin
         errors++; $display("FAIL midreset_read got re=%0d sc=%0d n=%0d pc=%0d want 1 %0d 1 %0d", o_re_n, o_strb_cyc, o_pulse_n, o_pulse_cyc, RL, RL + 2); end
      checks++; if (o_rdata !== exp || o_sacc !== 1'b1) begin errors++; $display("FAIL midreset_data got %h acc=%b want %h acc=1", o_rdata, o_sacc, exp); end
      @(negedge clk_i);
      read_request_i = 0;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_back_to_back;
      bit            wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d, exp;
      int            lat;
      for (int i = 0; i < 100; i++) begin
         wr  = 1'($urandom_range(0, 1));
         a   = 64'h200 + 64'($urandom_range(0, 15)) * 4;
         d   = $urandom;
         exp = ref_read(wr, a);
         lat = wr ? WL : RL;
         run_txn(wr, !wr, a, d);
         checks++; if (o_we_n !== int'(wr) || o_re_n !== int'(!wr) || o_maddr !== (a >> 2) || o_strb_cyc !== lat) begin
            errors++; $display("FAIL b2b_strobe[%0d] got we=%0d re=%0d a=%h cyc=%0d want wr=%0b a=%h cyc=%0d", i, o_we_n, o_re_n, o_maddr, o_strb_cyc, wr, a >> 2, lat); end
         checks++; if (o_pulse_n !== 1 || o_pulse_cyc !== lat + 2 || {o_swr, o_srd, o_sacc} !== {wr, !wr, 1'b1}) begin
            errors++; $display("FAIL b2b_pulse[%0d] got n=%0d cyc=%0d flags=%b want n=1 cyc=%0d wr=%0b", i, o_pulse_n, o_pulse_cyc, {o_swr, o_srd, o_sacc}, lat + 2, wr); end
         checks++; if (o_rdata !== exp) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, o_rdata, exp); end
         ref_apply(wr, a, d);
      end
   endtask

   initial begin
      test_reset;
      test_write_legal;
      test_read_legal;
      test_faults;
      test_simultaneous;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mem_latency_model.md
MEM_LATENCY_MODEL -- requirements
Module: mem_latency_model

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 32, word width.
- MEM_BYTES, 4096, size of the backing array in bytes.
- READ_LATENCY, 4, wait cycles before a read accesses the array (minimum 1).
- WRITE_LATENCY, 2, wait cycles before a write accesses the array (minimum 1).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1: the single clock, rising edge.
- arst_i, in, 1: asynchronous, active-low reset.
- write_en_i, in, 1: write request from the AXI4-Lite slave side, held until completion.
- read_request_i, in, 1: read request, held until completion.
- addr_i, in, ADDR_WIDTH: byte address.
- data_i, in, DATA_WIDTH: write data.
- read_data_o, out, DATA_WIDTH: read data.
- successful_access_o, out, 1: access was legal (level, valid with the completion pulses).
- successful_read_o, out, 1: one-cycle read completion pulse.
- successful_write_o, out, 1: one-cycle write completion pulse.
- mem_we_o, out, 1: array write strobe.
- mem_re_o, out, 1: array read strobe.
- mem_addr_o, out, ADDR_WIDTH: array word address (byte address >> 2).
- mem_data_o, out, DATA_WIDTH: array write data.
- mem_data_i, in, DATA_WIDTH: array read data, valid one cycle after mem_re_o.

Function
REQ-003 The FSM SHALL have the states IDLE, WAIT, ACCESS, RESP and HOLD.

REQ-004 In IDLE, when write_en_i or read_request_i is 1:
- addr_i, data_i and the kind are captured.
- The counter is loaded with LATENCY-1.
- The FSM goes to WAIT.

REQ-005 When write_en_i and read_request_i are both 1 in IDLE, the write SHALL be taken and the read ignored for that transaction.

REQ-006 In WAIT, the counter SHALL decrement each cycle; when it equals 0, the FSM goes to ACCESS. Total cycles from capture to ACCESS equal LATENCY.

REQ-007 An access SHALL fault when captured addr[1:0] != 0 or captured addr > MEM_BYTES-4.

REQ-008 In ACCESS, a legal access SHALL assert exactly one of mem_we_o or mem_re_o for one cycle, driving mem_addr_o and mem_data_o from the captured values. A faulted access asserts neither.

REQ-009 The FSM SHALL go ACCESS -> RESP unconditionally.

REQ-010 In RESP, for one cycle:
- successful_read_o or successful_write_o (matching the kind) is 1.
- successful_access_o = NOT fault.
- read_data_o is registered from mem_data_i for a legal read, and 0 for a fault or a write.

REQ-011 read_data_o SHALL hold its value until the next RESP.

REQ-012 In HOLD, the FSM SHALL stay until write_en_i and read_request_i are both 0, then go to IDLE. A held request is never accepted twice.

REQ-013 Requests arriving in WAIT, ACCESS, RESP or HOLD SHALL be ignored. addr_i and data_i changes after capture SHALL have no effect.

REQ-014 The counter SHALL be $clog2(max(READ_LATENCY, WRITE_LATENCY)+1) bits wide and SHALL never wrap below 0.

REQ-015 The latency from request capture to the completion pulse SHALL be LATENCY+2 cycles.

Reset
REQ-016 While arst_i=0, the FSM SHALL be in IDLE, the counter 0, and every output 0, including read_data_o.

REQ-017 An assertion of arst_i mid-transaction SHALL abort it with no array strobe and no completion pulse afterward.

REQ-018 After arst_i deasserts, a request still held high SHALL be accepted as new on the first clk_i edge.

Verification
REQ-019 Write, legal: addr 0x10, data 0xDEADBEEF, WRITE_LATENCY 2 -> mem_we_o one cycle at capture+2 with mem_addr_o 0x4 and mem_data_o 0xDEADBEEF; successful_write_o and successful_access_o = 1 at capture+4.

REQ-020 Read, legal: addr 0x10 with array returning 0xDEADBEEF, READ_LATENCY 4 -> mem_re_o at capture+4; successful_read_o = 1 at capture+6 with read_data_o 0xDEADBEEF.

REQ-021 Faults: addr 0x12 read, then addr 0x1000 write -> no mem strobes; completion pulses occur with successful_access_o = 0 and read_data_o = 0.

REQ-022 Simultaneous request: write_en_i and read_request_i both 1 -> write performed. With both held, no second transaction until both drop for at least one cycle.

REQ-023 Reset mid-operation: arst_i = 0 during WAIT of a write -> mem_we_o is never asserted and all outputs are 0. After release, a held read completes normally.

REQ-024 Back-to-back: 100 random legal reads and writes against a reference array -> data matches every time, and exactly one pulse occurs per request.
